// File: rtl/mac_col_acc.sv
// One column of a systolic attention array: holds a key vector, forms signed dot
// products against forwarded queries, and optionally accumulates acc_len of them.
module mac_col_acc #(
    parameter int bw       = 8,
    parameter int pr       = 8,
    parameter int bw_psum  = 2*bw+6,
    parameter int col_id   = 0,
    parameter int load_dly = 9,
    parameter int acc_len  = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [pr*bw-1:0]          q_in,
    input  logic [2:0]                i_inst,
    input  logic                      key_clr,
    output logic [pr*bw-1:0]          q_out,
    output logic [2:0]                o_inst,
    output logic signed [bw_psum-1:0] out,
    output logic                      out_valid,
    output logic                      fifo_wr,
    output logic                      err
);
    localparam int AW = bw_psum + $clog2(acc_len);
    localparam int CW = $clog2(acc_len);
    localparam int LW = $clog2(load_dly + 2);
    localparam logic [LW-1:0] LOAD_TGT = LW'(load_dly - col_id);
    localparam logic [CW-1:0] ACC_LAST = CW'(acc_len - 1);
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-bw_psum+1){1'b0}}, {(bw_psum-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-bw_psum+1){1'b1}}, {(bw_psum-1){1'b0}}};

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;

    logic [1:0]                state_q, state_d;
    logic [LW-1:0]             ld_cnt_q, ld_cnt_d;
    logic                      key_cap;
    logic [pr*bw-1:0]          key_q;
    logic [pr*bw-1:0]          query_q;
    logic [2:0]                inst_q;
    logic                      exe_q, exe_d;
    logic                      accm_q;
    logic signed [AW-1:0]      acc_q;
    logic [CW-1:0]             acc_cnt_q;
    logic signed [bw_psum-1:0] out_q;
    logic                      out_valid_q;
    logic                      err_q, err_d;
    logic signed [2*bw-1:0]    prod;
    logic signed [bw_psum-1:0] psum;
    logic signed [AW-1:0]      acc_sum;
    logic                      ex_only;

    function automatic logic signed [bw_psum-1:0] sat(input logic signed [AW-1:0] v);
        if (v > SAT_MAX)      sat = SAT_MAX[bw_psum-1:0];
        else if (v < SAT_MIN) sat = SAT_MIN[bw_psum-1:0];
        else                  sat = v[bw_psum-1:0];
    endfunction

    always_comb begin
        psum = '0;
        prod = '0;
        for (int k = 0; k < pr; k++) begin
            prod = (2*bw)'($signed(query_q[k*bw +: bw])) * (2*bw)'($signed(key_q[k*bw +: bw]));
            psum = psum + bw_psum'(prod);
        end
        acc_sum = acc_q + AW'(psum);
    end

    // A simultaneous load+execute is treated as a load; execute is only honoured in READY.
    assign ex_only = i_inst[1] & ~i_inst[0];

    always_comb begin
        state_d  = state_q;
        ld_cnt_d = ld_cnt_q;
        key_cap  = 1'b0;
        if (key_clr) begin
            state_d  = ST_IDLE;
            ld_cnt_d = '0;
        end else if (i_inst[0] && state_q != ST_READY) begin
            if (ld_cnt_q == LOAD_TGT) begin
                key_cap  = 1'b1;
                state_d  = ST_READY;
                ld_cnt_d = '0;
            end else begin
                state_d  = ST_LOAD;
                ld_cnt_d = ld_cnt_q + 1'b1;
            end
        end
        exe_d = ex_only && (state_q == ST_READY);
        err_d = err_q | (i_inst[0] & i_inst[1]) | (ex_only && (state_q != ST_READY));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            ld_cnt_q    <= '0;
            key_q       <= '0;
            query_q     <= '0;
            inst_q      <= '0;
            exe_q       <= 1'b0;
            accm_q      <= 1'b0;
            acc_q       <= '0;
            acc_cnt_q   <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q  <= state_d;
            ld_cnt_q <= ld_cnt_d;
            err_q    <= err_d;
            inst_q   <= i_inst;
            exe_q    <= exe_d;
            accm_q   <= i_inst[2];
            if (i_inst[0] | i_inst[1]) query_q <= q_in;
            if (key_cap)               key_q   <= q_in;
            out_valid_q <= 1'b0;
            // Second stage: psum reflects the query sampled one edge earlier.
            if (exe_q) begin
                if (accm_q) begin
                    if (acc_cnt_q == ACC_LAST) begin
                        out_q       <= sat(acc_sum);
                        out_valid_q <= 1'b1;
                        acc_q       <= '0;
                        acc_cnt_q   <= '0;
                    end else begin
                        acc_q     <= acc_sum;
                        acc_cnt_q <= acc_cnt_q + 1'b1;
                    end
                end else begin
                    out_q       <= psum;
                    out_valid_q <= 1'b1;
                    acc_q       <= '0;
                    acc_cnt_q   <= '0;
                end
            end
        end
    end

    assign q_out     = query_q;
    assign o_inst    = inst_q;
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign fifo_wr   = out_valid_q;
    assign err       = err_q;
endmodule
